// File: rtl/ext_divider.sv
// Multi-cycle RV32M divide unit on the external-execute port.
// Restoring radix-2 division, one quotient bit per cycle, with a fixed 34-cycle occupancy.
module ext_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] c,
   input  logic [9:0]      operation,
   output logic            bussy,
   output logic [XLEN-1:0] y
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [5:0]      cnt;
   logic [XLEN:0]   rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvs;
   logic            sel_rem;
   logic            neg_q;
   logic            neg_r;
   logic            div0;
   logic            ovf;

   logic            sgn;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic            unused_inputs;

   function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v);
      logic signed [XLEN-1:0] r;
      r = v[XLEN-1] ? -v : v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] final_result(
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r,
      input logic            sel_r,
      input logic            nq,
      input logic            nr,
      input logic            z,
      input logic            ov
   );
      logic [XLEN-1:0] qs;
      logic [XLEN-1:0] rs;
      qs = nq ? -q : q;
      // With a zero divisor every step subtracts nothing, so rs already equals the original dividend.
      rs = nr ? -r : r;
      if (sel_r)
         return ov ? '0 : rs;
      else if (z)
         return '1;
      else if (ov)
         return {1'b1, {(XLEN-1){1'b0}}};
      else
         return qs;
   endfunction

   assign sgn           = !operation[0];
   assign bussy         = en && operation[2] && (state != DONE);
   assign unused_inputs = ^{c, operation[9:3], rem[XLEN]};

   always_comb begin
      rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
      quo_nx = {quo[XLEN-2:0], 1'b0};
      rem_nx = rem_sh;
      if (rem_sh >= {1'b0, dvs}) begin
         rem_nx    = rem_sh - {1'b0, dvs};
         quo_nx[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         sel_rem <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
         ovf     <= 1'b0;
         y       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && operation[2]) begin
                  state   <= BUSY;
                  cnt     <= '0;
                  rem     <= '0;
                  quo     <= sgn ? mag($signed(a)) : a;
                  dvs     <= sgn ? mag($signed(b)) : b;
                  sel_rem <= operation[1];
                  neg_q   <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
                  neg_r   <= sgn && a[XLEN-1];
                  div0    <= (b == '0);
                  ovf     <= sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
               end
            end
            BUSY: begin
               // A dropped request is a flush: abandon the divide and keep the old result.
               if (!en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(XLEN-1)) begin
                     state <= DONE;
                     cnt   <= '0;
                     y     <= final_result(quo_nx, rem_nx[XLEN-1:0], sel_rem,
                                           neg_q, neg_r, div0, ovf);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
